spi_master_param: RTL and testbench

SPI_MASTER_PARAM -- requirements
Module: spi_master_param

---
 rtl/spi_master_param.sv | 163 ++++++++++++++++
 tb/tb_spi_master_param.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
// SPI master with run-time mode (CPOL/CPHA), compile-time width, clock divider and bit order.
// One transfer = SETUP (CLK_DIV cycles) + TX (2*DATA_W SCLK edges) + HOLD (CLK_DIV cycles).
module spi_master_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              SCLK,
  output logic              CS,
  output logic              DO,
  input  logic              DI
);

  localparam int unsigned EdgeW = $clog2(2 * DATA_W) + 1;
  localparam int unsigned DivW  = $clog2(CLK_DIV + 1);
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * DATA_W - 1);
  localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StTx, StHold} state_e;

  state_e             state_q, state_d;
  logic [DivW-1:0]    div_q;
  logic [EdgeW-1:0]   edge_q;
  logic               sclk_q;     // also holds the latched CPOL outside TX
  logic               cpha_q;
  logic               do_q;
  logic               ready_q;
  logic [DATA_W-1:0]  tx_sh_q;    // bits still to be presented on DO
  logic [DATA_W-1:0]  rx_sh_q;
  logic [DATA_W-1:0]  rx_data_q;
  logic               rx_valid_q;

  logic               accept;
  logic               div_done;
  logic               sclk_edge;
  logic               leading;
  logic [DATA_W-1:0]  rx_next;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  // Handshake, divider terminal count and edge classification.
  always_comb begin
    accept    = tx_valid && tx_ready;
    div_done  = (div_q == DivLast);
    sclk_edge = (state_q == StTx) && div_done;
    leading   = ~edge_q[0];
    // First sampled bit ends up where the first transmitted bit came from.
    rx_next   = (MSB_FIRST != 0) ? {rx_sh_q[DATA_W-2:0], DI} : {DI, rx_sh_q[DATA_W-1:1]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the divider paces every phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StSetup;
      StSetup: if (div_done) state_d = StTx;
      StTx:    if (div_done && (edge_q == LastEdge)) state_d = StHold;
      StHold:  if (div_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state and datapath registers.
  always_comb begin
    tx_ready = ready_q && (state_q == StIdle);
    busy     = (state_q != StIdle);
    CS       = (state_q == StIdle);
    SCLK     = sclk_q;
    DO       = (state_q == StIdle) ? 1'b0 : do_q;
    rx_valid = rx_valid_q;
    rx_data  = rx_data_q;
  end

  // Holds tx_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  // Counters, SCLK generation and the transmit shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      edge_q  <= '0;
      sclk_q  <= 1'b0;
      cpha_q  <= 1'b0;
      do_q    <= 1'b0;
      tx_sh_q <= '0;
    end else if (accept) begin
      div_q  <= '0;
      edge_q <= '0;
      sclk_q <= mode[1];
      cpha_q <= mode[0];
      if (mode[0]) begin
        // CPHA=1: first bit goes out on the first (leading) edge.
        tx_sh_q <= tx_data;
        do_q    <= 1'b0;
      end else begin
        // CPHA=0: first bit must be on DO before the first edge.
        tx_sh_q <= drop_bit(tx_data);
        do_q    <= first_bit(tx_data);
      end
    end else if (state_q != StIdle) begin
      div_q <= div_done ? '0 : div_q + DivW'(1);
      if (sclk_edge) begin
        sclk_q <= ~sclk_q;
        edge_q <= edge_q + EdgeW'(1);
        if (cpha_q ? leading : (!leading && (edge_q != LastEdge))) begin
          do_q    <= first_bit(tx_sh_q);
          tx_sh_q <= drop_bit(tx_sh_q);
        end
      end
    end
  end

  // Receive shifter and the completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (accept) begin
        rx_sh_q <= '0;
      end else if (sclk_edge && (leading != cpha_q)) begin
        rx_sh_q <= rx_next;
      end
      if ((state_q == StHold) && div_done) begin
        rx_valid_q <= 1'b1;
        rx_data_q  <= rx_sh_q;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: three instances cover MSB-first/div 2, LSB-first/div 3 and
// MSB-first/div 1. Transfers are observed on the pins and compared with a bit-level model.
module tb_spi_master_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [1:0] mode = 2'b00;
  logic [2:0] tx_valid = 3'b000;
  logic [2:0] rdy, rxv, bsy, sck, csn, dout, din;
  logic [7:0] rxd [3];
  logic [2:0] di_loop = 3'b111;
  logic [2:0] di_val = 3'b000;

  int total = 0;
  int bad = 0;

  // Observations filled in by run_xfer.
  int         ob_cs_low, ob_rises, ob_toggles, ob_nsamp, ob_rxv_early;
  bit         ob_tmo;
  logic [7:0] ob_do_seq, ob_rxd, ob_rxd_after;
  logic       ob_first_do, ob_setup_sclk, ob_end_sclk, ob_busy_setup, ob_ready_setup;
  logic       ob_rxv_rise, ob_rxv_after;

  always #5 clk = ~clk;

  assign din = (di_loop & dout) | (~di_loop & di_val);

  spi_master_param #(.DATA_W(8), .CLK_DIV(2), .MSB_FIRST(1)) u0 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid[0]), .tx_ready(rdy[0]),
    .mode(mode), .rx_data(rxd[0]), .rx_valid(rxv[0]), .busy(bsy[0]), .SCLK(sck[0]),
    .CS(csn[0]), .DO(dout[0]), .DI(din[0])
  );

  spi_master_param #(.DATA_W(8), .CLK_DIV(3), .MSB_FIRST(0)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid[1]), .tx_ready(rdy[1]),
    .mode(mode), .rx_data(rxd[1]), .rx_valid(rxv[1]), .busy(bsy[1]), .SCLK(sck[1]),
    .CS(csn[1]), .DO(dout[1]), .DI(din[1])
  );

  spi_master_param #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(1)) u2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid[2]), .tx_ready(rdy[2]),
    .mode(mode), .rx_data(rxd[2]), .rx_valid(rxv[2]), .busy(bsy[2]), .SCLK(sck[2]),
    .CS(csn[2]), .DO(dout[2]), .DI(din[2])
  );

  function automatic int cd_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 3 : 1);
  endfunction

  function automatic bit msb_of(input int d);
    return (d != 1);
  endfunction

  // Order in which the word's bits must appear on the wire, first bit in [7].
  function automatic logic [7:0] exp_seq(input logic [7:0] w, input bit msb);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = {s[6:0], msb ? w[7 - i] : w[i]};
    return s;
  endfunction

  // Starts one transfer on instance d and records what the pins did.
  task automatic run_xfer(input int d, input logic [7:0] w, input logic [1:0] md);
    logic prev;
    int   cyc;
    ob_cs_low = 0; ob_rises = 0; ob_toggles = 0; ob_nsamp = 0; ob_rxv_early = 0;
    ob_do_seq = '0; ob_tmo = 1'b0;
    cyc = 0;
    while (rdy[d] !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    tx_data = w;
    mode = md;
    tx_valid[d] = 1'b1;
    @(negedge clk);
    tx_valid[d] = 1'b0;
    tx_data = 8'($urandom);
    mode = 2'($urandom);
    ob_busy_setup = bsy[d];
    ob_ready_setup = rdy[d];
    ob_setup_sclk = sck[d];
    ob_first_do = dout[d];
    prev = sck[d];
    cyc = 0;
    while (csn[d] === 1'b0 && cyc < 400) begin
      ob_cs_low++;
      @(negedge clk);
      cyc++;
      if (sck[d] !== prev) begin
        ob_toggles++;
        if (sck[d] === 1'b1) ob_rises++;
        // Sampling edge is rising when CPOL==CPHA, falling otherwise.
        if (sck[d] === ~(md[1] ^ md[0])) begin
          ob_do_seq = {ob_do_seq[6:0], dout[d]};
          ob_nsamp++;
        end
        prev = sck[d];
      end
      if (csn[d] === 1'b0 && rxv[d] === 1'b1) ob_rxv_early++;
    end
    ob_tmo = (cyc >= 400);
    ob_rxv_rise = rxv[d];
    ob_rxd = rxd[d];
    ob_end_sclk = sck[d];
    @(negedge clk);
    ob_rxv_after = rxv[d];
    ob_rxd_after = rxd[d];
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({csn, sck, dout, rdy, bsy, rxv} !== {3'b111, 15'b0}) begin
      bad++;
      $display("FAIL reset_outputs: got %b want %b", {csn, sck, dout, rdy, bsy, rxv},
               {3'b111, 15'b0});
    end
    for (int d = 0; d < 3; d++) begin
      total++;
      if (rxd[d] !== 8'h00) begin
        bad++;
        $display("FAIL reset_rx_data[%0d]: got %h want 00", d, rxd[d]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (rdy !== 3'b000) begin
      bad++;
      $display("FAIL ready_before_edge: got %b want 000", rdy);
    end
    @(negedge clk);
    total++;
    if (rdy !== 3'b111) begin
      bad++;
      $display("FAIL ready_after_edge: got %b want 111", rdy);
    end
  endtask

  task automatic test_transfers();
    int         d_t[$];
    logic [7:0] w_t[$];
    logic [1:0] m_t[$];
    bit         lp_t[$];
    bit         dv_t[$];
    // Directed: mode0 loopback 0xB1, mode3 DI=1, LSB-first 0x01, div-1 mode1.
    d_t = '{0, 0, 1, 2};
    w_t = '{8'hB1, 8'h5A, 8'h01, 8'hC3};
    m_t = '{2'd0, 2'd3, 2'd0, 2'd1};
    lp_t = '{1'b1, 1'b0, 1'b1, 1'b1};
    dv_t = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 24; k++) begin
      d_t.push_back(int'($urandom_range(0, 2)));
      w_t.push_back(8'($urandom));
      m_t.push_back(2'($urandom));
      lp_t.push_back(1'($urandom));
      dv_t.push_back(1'($urandom));
    end
    foreach (d_t[k]) begin
      int         d;
      logic [7:0] ex_seq, ex_rx;
      int         ex_cs;
      d = d_t[k];
      di_loop[d] = lp_t[k];
      di_val[d] = dv_t[k];
      ex_seq = exp_seq(w_t[k], msb_of(d));
      ex_rx = lp_t[k] ? w_t[k] : {8{dv_t[k]}};
      ex_cs = 18 * cd_of(d);
      run_xfer(d, w_t[k], m_t[k]);
      total++;
      if (ob_tmo) begin
        bad++;
        $display("FAIL xfer%0d_timeout: cs still low after 400 cycles, want done", k);
      end
      total++;
      if (ob_cs_low != ex_cs) begin
        bad++;
        $display("FAIL xfer%0d_cs_low: got %0d want %0d", k, ob_cs_low, ex_cs);
      end
      total++;
      if (ob_rises != 8 || ob_toggles != 16) begin
        bad++;
        $display("FAIL xfer%0d_edges: got rises=%0d toggles=%0d want 8/16", k, ob_rises,
                 ob_toggles);
      end
      total++;
      if (ob_nsamp != 8 || ob_do_seq !== ex_seq) begin
        bad++;
        $display("FAIL xfer%0d_do_bits: got %b (%0d) want %b (8)", k, ob_do_seq, ob_nsamp,
                 ex_seq);
      end
      total++;
      if (ob_setup_sclk !== m_t[k][1] || ob_end_sclk !== m_t[k][1]) begin
        bad++;
        $display("FAIL xfer%0d_sclk_idle: got setup=%b end=%b want %b", k, ob_setup_sclk,
                 ob_end_sclk, m_t[k][1]);
      end
      total++;
      if ({ob_busy_setup, ob_ready_setup} !== 2'b10) begin
        bad++;
        $display("FAIL xfer%0d_busy_ready: got %b want 10", k, {ob_busy_setup, ob_ready_setup});
      end
      if (m_t[k][0] == 1'b0) begin
        total++;
        if (ob_first_do !== ex_seq[7]) begin
          bad++;
          $display("FAIL xfer%0d_first_do: got %b want %b", k, ob_first_do, ex_seq[7]);
        end
      end
      total++;
      if ({ob_rxv_early != 0, ob_rxv_rise, ob_rxv_after} !== 3'b010) begin
        bad++;
        $display("FAIL xfer%0d_rx_valid: got early/rise/after=%0d/%b/%b want 0/1/0", k,
                 ob_rxv_early, ob_rxv_rise, ob_rxv_after);
      end
      total++;
      if (ob_rxd !== ex_rx || ob_rxd_after !== ex_rx) begin
        bad++;
        $display("FAIL xfer%0d_rx_data: got %h then %h want %h", k, ob_rxd, ob_rxd_after, ex_rx);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    di_loop[0] = 1'b1;
    cyc = 0;
    while (rdy[0] !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    tx_data = 8'h11;
    mode = 2'b00;
    tx_valid[0] = 1'b1;
    @(negedge clk);
    total++;
    if (csn[0] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_first_accept: got cs=%b want 0", csn[0]);
    end
    // Changes here land only at the second accept.
    tx_data = 8'h22;
    mode = 2'b01;
    cyc = 0;
    while (rxv[0] !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (rxv[0] !== 1'b1 || rxd[0] !== 8'h11 || csn[0] !== 1'b1 || rdy[0] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first_done: got rxv=%b rx=%h cs=%b rdy=%b want 1/11/1/1", rxv[0],
               rxd[0], csn[0], rdy[0]);
    end
    @(negedge clk);
    tx_valid[0] = 1'b0;
    total++;
    if (csn[0] !== 1'b0 || bsy[0] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second_accept: got cs=%b busy=%b want 0/1", csn[0], bsy[0]);
    end
    cyc = 0;
    while (rxv[0] !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (rxv[0] !== 1'b1 || rxd[0] !== 8'h22) begin
      bad++;
      $display("FAIL b2b_second_done: got rxv=%b rx=%h want 1/22", rxv[0], rxd[0]);
    end
  endtask

  task automatic test_abort();
    int   cyc, n, cnt;
    logic prev;
    di_loop[0] = 1'b1;
    cyc = 0;
    while (rdy[0] !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    tx_data = 8'h3C;
    mode = 2'b00;
    tx_valid[0] = 1'b1;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    prev = sck[0];
    n = 0;
    cyc = 0;
    while (n < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (sck[0] !== prev) begin
        n++;
        prev = sck[0];
      end
    end
    total++;
    if (n != 3 || sck[0] !== 1'b1) begin
      bad++;
      $display("FAIL abort_edges: got edges=%0d sclk=%b want 3/1", n, sck[0]);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({csn[0], sck[0], dout[0], rdy[0], bsy[0], rxv[0]} !== 6'b100000 || rxd[0] !== 8'h00)
    begin
      bad++;
      $display("FAIL abort_reset_pins: got %b rx=%h want 100000 rx=00",
               {csn[0], sck[0], dout[0], rdy[0], bsy[0], rxv[0]}, rxd[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (rxv[0] === 1'b1 || csn[0] !== 1'b1) cnt++;
    end
    total++;
    if (cnt != 0) begin
      bad++;
      $display("FAIL abort_quiet: got %0d cycles with rx_valid or cs low want 0", cnt);
    end
    run_xfer(0, 8'hA5, 2'b00);
    total++;
    if (ob_rxd !== 8'hA5 || ob_rxv_rise !== 1'b1 || ob_cs_low != 36) begin
      bad++;
      $display("FAIL abort_next_xfer: got rx=%h rxv=%b cs_low=%0d want a5/1/36", ob_rxd,
               ob_rxv_rise, ob_cs_low);
    end
  endtask

  initial begin
    test_reset();
    test_transfers();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
